// File: rtl/ds_packet_sender.sv
// Data-stream packet sender: buffers fabric words in a show-ahead FIFO and frames
// them into SOP/EOP packets sent round-robin to a list of NAP destinations.
module ds_packet_sender #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 4,
    parameter int IN_WIDTH   = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int PKT_BEATS  = 4,
    parameter int NUM_DEST   = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [NUM_DEST*ADDR_WIDTH-1:0] dest_list,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [IN_WIDTH-1:0]            in_data,
    output logic                           ds_valid,
    input  logic                           ds_ready,
    output logic                           ds_sop,
    output logic                           ds_eop,
    output logic [ADDR_WIDTH-1:0]          ds_addr,
    output logic [DATA_WIDTH-1:0]          ds_data,
    output logic [31:0]                    pkt_count,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [LW-1:0] DEPTH_L     = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] BEATS_L     = LW'(PKT_BEATS);
    localparam logic [TW-1:0] TIMEOUT_L   = TW'(TIMEOUT);
    localparam logic [DW-1:0] LAST_DEST_L = DW'(NUM_DEST - 1);
    localparam logic          TMO_EN      = (TIMEOUT != 0);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                  state_r;
    logic [IN_WIDTH-1:0]     mem_r [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_r;
    logic [PW-1:0]           rd_ptr_r;
    logic [LW-1:0]           level_r;
    logic [LW-1:0]           len_r;
    logic [LW-1:0]           beat_r;
    logic [DW-1:0]           dest_idx_r;
    logic [TW-1:0]           idle_cnt_r;
    logic [31:0]             pkt_count_r;
    logic                    ds_valid_r;
    logic                    ds_sop_r;
    logic                    ds_eop_r;
    logic [ADDR_WIDTH-1:0]   ds_addr_r;
    logic [DATA_WIDTH-1:0]   ds_data_r;

    logic                    in_ready_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    start_full_s;
    logic                    start_tmo_s;
    logic                    start_s;
    logic [LW-1:0]           start_len_s;
    logic [IN_WIDTH-1:0]     head_s;
    logic [IN_WIDTH-1:0]     next_word_s;
    logic [ADDR_WIDTH-1:0]   dest_arr_s [NUM_DEST];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(FIFO_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    for (genvar g = 0; g < NUM_DEST; g++) begin : g_dest
        assign dest_arr_s[g] = dest_list[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // in_ready depends only on the registered level, never on ds_ready
    assign in_ready_s   = resetn && (level_r < DEPTH_L);
    assign push_s       = in_valid && in_ready_s;
    assign pop_s        = ds_valid_r && ds_ready;
    assign head_s       = mem_r[rd_ptr_r];
    assign next_word_s  = mem_r[ptr_inc(rd_ptr_r)];

    assign start_full_s = (level_r >= BEATS_L);
    assign start_tmo_s  = TMO_EN && (level_r != '0) && (idle_cnt_r == TIMEOUT_L);
    assign start_s      = start_full_s || start_tmo_s;
    assign start_len_s  = start_full_s ? BEATS_L : level_r;

    // FIFO storage, written on every accepted input word
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Idle timer for short-packet flush; held at zero outside IDLE
    always_ff @(posedge clk) begin
        if (!resetn) begin
            idle_cnt_r <= '0;
        end else if (push_s || (state_r != ST_IDLE)) begin
            idle_cnt_r <= '0;
        end else if ((level_r != '0) && (level_r < BEATS_L) && (idle_cnt_r != TIMEOUT_L)) begin
            idle_cnt_r <= idle_cnt_r + TW'(1);
        end else begin
            idle_cnt_r <= idle_cnt_r;
        end
    end

    // Packet framing FSM with registered data-stream outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            len_r       <= '0;
            beat_r      <= '0;
            dest_idx_r  <= '0;
            pkt_count_r <= 32'd0;
            ds_valid_r  <= 1'b0;
            ds_sop_r    <= 1'b0;
            ds_eop_r    <= 1'b0;
            ds_addr_r   <= '0;
            ds_data_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r    <= ST_SEND;
                        len_r      <= start_len_s;
                        beat_r     <= '0;
                        ds_valid_r <= 1'b1;
                        ds_sop_r   <= 1'b1;
                        ds_eop_r   <= (start_len_s == LW'(1));
                        ds_addr_r  <= dest_arr_s[dest_idx_r];
                        ds_data_r  <= DATA_WIDTH'(head_s);
                    end
                end
                ST_SEND: begin
                    if (pop_s) begin
                        beat_r <= beat_r + LW'(1);
                        if (ds_eop_r) begin
                            state_r     <= ST_IDLE;
                            ds_valid_r  <= 1'b0;
                            ds_sop_r    <= 1'b0;
                            ds_eop_r    <= 1'b0;
                            ds_data_r   <= '0;
                            pkt_count_r <= pkt_count_r + 32'd1;
                            dest_idx_r  <= (dest_idx_r == LAST_DEST_L) ? '0 : dest_idx_r + DW'(1);
                        end else begin
                            // next head is already resident: len never exceeds the level at start
                            ds_sop_r  <= 1'b0;
                            ds_eop_r  <= ((beat_r + LW'(2)) == len_r);
                            ds_data_r <= DATA_WIDTH'(next_word_s);
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    ds_valid_r <= 1'b0;
                    ds_sop_r   <= 1'b0;
                    ds_eop_r   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_s;
    assign ds_valid   = ds_valid_r;
    assign ds_sop     = ds_sop_r;
    assign ds_eop     = ds_eop_r;
    assign ds_addr    = ds_addr_r;
    assign ds_data    = ds_data_r;
    assign pkt_count  = pkt_count_r;
    assign fifo_level = level_r;

endmodule

// File: tb/tb_ds_packet_sender.sv
// Directed bench for ds_packet_sender: table-driven round-robin framing plus
// hand sequences for reset, timeout flush, backpressure, FIFO full and 1-beat packets.
`timescale 1ns/1ps
module tb_ds_packet_sender;
    localparam int DW = 256;
    localparam int AW = 4;
    localparam int IW = 32;
    localparam int LW = 5;

    localparam logic [3*AW-1:0] A_DEST = {4'd3, 4'd7, 4'd2};
    localparam logic [2*AW-1:0] B_DEST = {4'd9, 4'd5};

    logic          clk      = 1'b0;
    logic          resetn   = 1'b0;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_data  = 32'd0;
    logic          ds_ready = 1'b0;

    logic a_in_ready, a_valid, a_sop, a_eop;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic [31:0]   a_pkt;
    logic [LW-1:0] a_level;
    logic b_in_ready, b_valid, b_sop, b_eop;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic [31:0]   b_pkt;
    logic [LW-1:0] b_level;
    logic c_in_ready, c_valid, c_sop, c_eop;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_data;
    logic [31:0]   c_pkt;
    logic [LW-1:0] c_level;

    ds_packet_sender #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IN_WIDTH(IW), .FIFO_DEPTH(16),
                       .PKT_BEATS(4), .NUM_DEST(3), .TIMEOUT(64)) dut_a (
        .clk(clk), .resetn(resetn), .dest_list(A_DEST), .in_valid(in_valid),
        .in_ready(a_in_ready), .in_data(in_data), .ds_valid(a_valid), .ds_ready(ds_ready),
        .ds_sop(a_sop), .ds_eop(a_eop), .ds_addr(a_addr), .ds_data(a_data),
        .pkt_count(a_pkt), .fifo_level(a_level));

    ds_packet_sender #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IN_WIDTH(IW), .FIFO_DEPTH(16),
                       .PKT_BEATS(1), .NUM_DEST(2), .TIMEOUT(64)) dut_b (
        .clk(clk), .resetn(resetn), .dest_list(B_DEST), .in_valid(in_valid),
        .in_ready(b_in_ready), .in_data(in_data), .ds_valid(b_valid), .ds_ready(ds_ready),
        .ds_sop(b_sop), .ds_eop(b_eop), .ds_addr(b_addr), .ds_data(b_data),
        .pkt_count(b_pkt), .fifo_level(b_level));

    ds_packet_sender #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IN_WIDTH(IW), .FIFO_DEPTH(16),
                       .PKT_BEATS(4), .NUM_DEST(3), .TIMEOUT(0)) dut_c (
        .clk(clk), .resetn(resetn), .dest_list(A_DEST), .in_valid(in_valid),
        .in_ready(c_in_ready), .in_data(in_data), .ds_valid(c_valid), .ds_ready(ds_ready),
        .ds_sop(c_sop), .ds_eop(c_eop), .ds_addr(c_addr), .ds_data(c_data),
        .pkt_count(c_pkt), .fifo_level(c_level));

    always #5 clk = ~clk;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic          hi;
        logic [AW-1:0] addr;
        logic [IW-1:0] data;
    } beat_t;

    typedef struct {
        logic          iv;
        logic [IW-1:0] id;
        logic          rdy;
        logic          ev;
        logic          es;
        logic          ee;
        logic [AW-1:0] ea;
        logic [IW-1:0] ed;
    } vec_t;

    vec_t  tbl [20];
    beat_t a_q [$];
    beat_t b_q [$];
    beat_t c_q [$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Beat monitors: record every handshake, sampled mid-cycle once inputs settle
    always @(negedge clk) begin
        #1;
        if (resetn && ds_ready && a_valid)
            a_q.push_back('{sop: a_sop, eop: a_eop, hi: |a_data[DW-1:IW], addr: a_addr, data: a_data[IW-1:0]});
        if (resetn && ds_ready && b_valid)
            b_q.push_back('{sop: b_sop, eop: b_eop, hi: |b_data[DW-1:IW], addr: b_addr, data: b_data[IW-1:0]});
        if (resetn && c_valid)
            c_q.push_back('{sop: c_sop, eop: c_eop, hi: |c_data[DW-1:IW], addr: c_addr, data: c_data[IW-1:0]});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    function automatic beat_t mk(input logic s, input logic e, input logic [AW-1:0] a, input logic [IW-1:0] d);
        return '{sop: s, eop: e, hi: 1'b0, addr: a, data: d};
    endfunction

    task automatic check_beat(input string name, input beat_t q[$], input int idx, input beat_t exp);
        beat_t got;
        got = '0;
        if (idx < q.size()) got = q[idx];
        check($sformatf("%s[%0d]", name, idx), 128'(got), 128'(exp));
    endtask

    task automatic set_beat(input int i, input logic s, input logic e, input logic [AW-1:0] a, input logic [IW-1:0] d);
        tbl[i].ev = 1'b1;
        tbl[i].es = s;
        tbl[i].ee = e;
        tbl[i].ea = a;
        tbl[i].ed = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn   = 1'b0;
        in_valid = 1'b0;
        ds_ready = 1'b0;
        in_data  = 32'd0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        a_q.delete();
        b_q.delete();
        c_q.delete();
    endtask

    task automatic push_words(input logic [IW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = base + 32'(i);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int acc;
        int n;
        logic [AW-1:0] rr [4];

        // Round-robin table: words 1..12 pushed in cycles 0..11 with ds_ready high
        for (int i = 0; i < 20; i++) begin
            tbl[i].iv  = (i < 12);
            tbl[i].id  = 32'(i + 1);
            tbl[i].rdy = 1'b1;
            tbl[i].ev  = 1'b0;
            tbl[i].es  = 1'b0;
            tbl[i].ee  = 1'b0;
            tbl[i].ea  = 4'd0;
            tbl[i].ed  = 32'd0;
        end
        set_beat(5,  1'b1, 1'b0, 4'd2, 32'd1);
        set_beat(6,  1'b0, 1'b0, 4'd2, 32'd2);
        set_beat(7,  1'b0, 1'b0, 4'd2, 32'd3);
        set_beat(8,  1'b0, 1'b1, 4'd2, 32'd4);
        set_beat(10, 1'b1, 1'b0, 4'd7, 32'd5);
        set_beat(11, 1'b0, 1'b0, 4'd7, 32'd6);
        set_beat(12, 1'b0, 1'b0, 4'd7, 32'd7);
        set_beat(13, 1'b0, 1'b1, 4'd7, 32'd8);
        set_beat(15, 1'b1, 1'b0, 4'd3, 32'd9);
        set_beat(16, 1'b0, 1'b0, 4'd3, 32'd10);
        set_beat(17, 1'b0, 1'b0, 4'd3, 32'd11);
        set_beat(18, 1'b0, 1'b1, 4'd3, 32'd12);

        // ---- Reset mid-packet ----
        do_reset();
        check("rst_ds", 128'({a_valid, a_sop, a_eop, a_addr, a_data}), 128'(0));
        check("rst_cnt", 128'({a_pkt, a_level}), 128'(0));
        ds_ready = 1'b1;
        push_words(32'h11, 4);
        @(negedge clk);
        check("mid_beat0", 128'({a_valid, a_sop, a_eop, a_addr, a_data[IW-1:0]}), 128'({1'b1, 1'b1, 1'b0, 4'd2, 32'h11}));
        @(negedge clk);
        check("mid_beat1", 128'({a_valid, a_sop, a_eop, a_addr, a_data[IW-1:0]}), 128'({1'b1, 1'b0, 1'b0, 4'd2, 32'h12}));
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("mid_rst_ds", 128'({a_valid, a_sop, a_eop, a_addr, a_data}), 128'(0));
        check("mid_rst_cnt", 128'({a_in_ready, a_pkt, a_level}), 128'(0));
        resetn = 1'b1;
        a_q.delete();
        repeat (20) @(negedge clk);
        check("mid_no_valid", 128'(a_q.size()), 128'(0));
        check("mid_pkt0", 128'(a_pkt), 128'(0));
        push_words(32'h15, 4);
        repeat (8) @(negedge clk);
        check("mid_new_n", 128'(a_q.size()), 128'(4));
        check_beat("mid_new", a_q, 0, mk(1'b1, 1'b0, 4'd2, 32'h15));
        check_beat("mid_new", a_q, 3, mk(1'b0, 1'b1, 4'd2, 32'h18));

        // ---- Round-robin full packets (table) ----
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = tbl[i].iv;
            in_data  = tbl[i].id;
            ds_ready = tbl[i].rdy;
            if (tbl[i].ev)
                check($sformatf("rr_c%0d", i),
                      128'({a_valid, a_sop, a_eop, |a_data[DW-1:IW], a_addr, a_data[IW-1:0]}),
                      128'({1'b1, tbl[i].es, tbl[i].ee, 1'b0, tbl[i].ea, tbl[i].ed}));
            else
                check($sformatf("rr_c%0d_idle", i), 128'(a_valid), 128'(0));
        end
        check("rr_pkt", 128'(a_pkt), 128'(3));
        check("rr_level", 128'(a_level), 128'(0));

        // ---- Timeout flush (A) and disabled flush (C) ----
        do_reset();
        ds_ready = 1'b1;
        push_words(32'h21, 3);
        n = 1;
        while (!a_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tmo_latency", 128'(n), 128'(66));
        repeat (5) @(negedge clk);
        check("tmo_n", 128'(a_q.size()), 128'(3));
        check_beat("tmo", a_q, 0, mk(1'b1, 1'b0, 4'd2, 32'h21));
        check_beat("tmo", a_q, 1, mk(1'b0, 1'b0, 4'd2, 32'h22));
        check_beat("tmo", a_q, 2, mk(1'b0, 1'b1, 4'd2, 32'h23));
        repeat (100) @(negedge clk);
        check("tmo0_none", 128'(c_q.size()), 128'(0));
        check("tmo0_state", 128'({c_in_ready, c_pkt, c_level}), 128'({1'b1, 32'd0, 5'd3}));

        // ---- Backpressure mid-packet ----
        do_reset();
        ds_ready = 1'b1;
        push_words(32'h31, 4);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            ds_ready = 1'b0;
            check($sformatf("bp_hold%0d", k),
                  128'({a_valid, a_sop, a_eop, a_addr, a_data[IW-1:0]}),
                  128'({1'b1, 1'b0, 1'b0, 4'd2, 32'h32}));
        end
        @(negedge clk);
        ds_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("bp_n", 128'(a_q.size()), 128'(4));
        for (int i = 0; i < 4; i++)
            check_beat("bp", a_q, i, mk(i == 0, i == 3, 4'd2, 32'h31 + 32'(i)));
        check("bp_pkt", 128'(a_pkt), 128'(1));

        // ---- FIFO full, then drain ----
        do_reset();
        acc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'h41 + 32'(acc);
            if (a_in_ready) acc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("full_accepted", 128'(acc), 128'(16));
        check("full_level", 128'({a_in_ready, a_level}), 128'({1'b0, 5'd16}));
        check("full_no_pop", 128'(a_q.size()), 128'(0));
        ds_ready = 1'b1;
        repeat (30) @(negedge clk);
        rr[0] = 4'd2; rr[1] = 4'd7; rr[2] = 4'd3; rr[3] = 4'd2;
        check("full_n", 128'(a_q.size()), 128'(16));
        for (int i = 0; i < 16; i++)
            check_beat("full", a_q, i, mk((i % 4) == 0, (i % 4) == 3, rr[i / 4], 32'h41 + 32'(i)));
        check("full_pkt", 128'({a_pkt, a_level}), 128'({32'd4, 5'd0}));

        // ---- Single-beat packets (B) ----
        do_reset();
        ds_ready = 1'b1;
        push_words(32'h61, 2);
        repeat (6) @(negedge clk);
        check("one_n", 128'(b_q.size()), 128'(2));
        check_beat("one", b_q, 0, mk(1'b1, 1'b1, 4'd5, 32'h61));
        check_beat("one", b_q, 1, mk(1'b1, 1'b1, 4'd9, 32'h62));
        check("one_pkt", 128'({b_in_ready, b_pkt, b_level}), 128'({1'b1, 32'd2, 5'd0}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
